// File: rtl/div_share_ctrl.sv
// Shared repeated-subtraction divider with a two-port round-robin arbiter.
// One subtraction runs per clock, and each result is returned with a valid pulse tagged with its owner.
module div_share_ctrl #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         valid,
    output logic         id,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem,
    output logic         dz
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state;
    logic         ptr;
    logic         owner;
    logic [W-1:0] r;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         pick;

    // When both requesters compete, the round-robin pointer decides; otherwise the lone requester wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ptr;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            ptr   <= 1'b0;
            owner <= 1'b0;
            r     <= '0;
            d     <= '0;
            q     <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            busy  <= 1'b0;
            valid <= 1'b0;
            id    <= 1'b0;
            quo   <= '0;
            rem   <= '0;
            dz    <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r     <= pick ? a1 : a0;
                        d     <= pick ? b1 : b0;
                        q     <= '0;
                        owner <= pick;
                        gnt0  <= ~pick;
                        gnt1  <= pick;
                        busy  <= 1'b1;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (d == '0) begin
                        quo   <= '1;
                        rem   <= r;
                        dz    <= 1'b1;
                        id    <= owner;
                        valid <= 1'b1;
                        state <= S_DONE;
                    end else if (r >= d) begin
                        r <= r - d;
                        q <= q + 1'b1;
                    end else begin
                        quo   <= q;
                        rem   <= r;
                        dz    <= 1'b0;
                        id    <= owner;
                        valid <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ptr   <= ~id;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl covering grant timing, result latency, divide-by-zero,
// round-robin alternation and asynchronous reset in the middle of a calculation.
module tb_div_share_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [4:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, busy, valid, id, dz;
    logic [4:0] quo, rem;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_share_ctrl #(.W(5)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .valid(valid),
        .id(id), .quo(quo), .rem(rem), .dz(dz)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic [4:0] x0, input logic [4:0] y0,
                                 input logic r1, input logic [4:0] x1, input logic [4:0] y1);
        req0 = r0; a0 = x0; b0 = y0;
        req1 = r1; a1 = x1; b1 = y1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_gnt0"}, gnt0, 0);
        checkOutput({tag, "_gnt1"}, gnt1, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_valid"}, valid, 0);
        checkOutput({tag, "_id"}, id, 0);
        checkOutput({tag, "_quo"}, quo, 0);
        checkOutput({tag, "_rem"}, rem, 0);
        checkOutput({tag, "_dz"}, dz, 0);
    endtask

    // Expects IDLE with requests already driven; the next edge is the grant edge E0.
    task automatic runOp(input string tag, input logic expOwner, input int expEdges,
                         input logic [4:0] expQuo, input logic [4:0] expRem, input logic expDz);
        int   n;
        logic sawValid;
        logic extraGnt;
        @(posedge clk); #1;
        checkOutput({tag, "_gnt0"}, gnt0, !expOwner);
        checkOutput({tag, "_gnt1"}, gnt1, expOwner);
        checkOutput({tag, "_busy_calc"}, busy, 1);
        if (expOwner) req1 = 1'b0;
        else          req0 = 1'b0;
        n = 0; sawValid = 1'b0; extraGnt = 1'b0;
        while (!sawValid && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (valid) sawValid = 1'b1;
            else if (gnt0 || gnt1) extraGnt = 1'b1;
        end
        checkOutput({tag, "_valid_seen"}, sawValid, 1);
        checkOutput({tag, "_latency"}, n, expEdges);
        checkOutput({tag, "_no_gnt_busy"}, extraGnt, 0);
        checkOutput({tag, "_busy_done"}, busy, 1);
        checkOutput({tag, "_id"}, id, expOwner);
        checkOutput({tag, "_quo"}, quo, expQuo);
        checkOutput({tag, "_rem"}, rem, expRem);
        checkOutput({tag, "_dz"}, dz, expDz);
        @(posedge clk); #1;
        checkOutput({tag, "_valid_pulse"}, valid, 0);
        checkOutput({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        int pulses;
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #22;
        checkIdleOutputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        applyStimulus(1, 23, 5, 0, 0, 0);
        runOp("op23_5", 0, 5, 4, 3, 0);
        applyStimulus(0, 0, 0, 1, 31, 1);
        runOp("op31_1", 1, 32, 31, 0, 0);
        applyStimulus(0, 0, 0, 1, 3, 7);
        runOp("op3_7", 1, 1, 0, 3, 0);
        applyStimulus(1, 7, 0, 0, 0, 0);
        runOp("op7_0", 0, 1, 31, 7, 1);
        applyStimulus(1, 10, 3, 0, 0, 0);
        runOp("op10_3", 0, 4, 3, 1, 0);

        // Fresh reset so the pointer starts at requester 0 for the contention test.
        rst = 1'b0;
        #3;
        rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 20, 6, 1, 9, 3);
        runOp("both_first", 0, 4, 3, 2, 0);
        runOp("both_second", 1, 4, 3, 0, 0);
        applyStimulus(1, 20, 6, 1, 9, 3);
        runOp("both_third", 0, 4, 3, 2, 0);
        req1 = 1'b0;

        applyStimulus(1, 31, 1, 0, 0, 0);
        @(posedge clk); #1;
        checkOutput("abort_gnt0", gnt0, 1);
        req0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        checkIdleOutputs("abort_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid || busy) pulses++;
        end
        checkOutput("abort_no_valid", pulses, 0);
        applyStimulus(1, 20, 6, 1, 9, 3);
        runOp("after_reset", 0, 4, 3, 2, 0);
        req1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
